// File: rtl/i2c_pkg.sv
// Shared definitions for the board-level I2C bus arbiter and the I2C
// transaction engines: state encoding, counter/index widths, default
// 50 MHz timing constants and a small modulo helper for requester indices.
package i2c_pkg;

   // Width of every timing counter.
   localparam int CNT_W = 29;
   // Width of a requester index (up to 8 requesters).
   localparam int IDX_W = 3;

   // Default timing at 50 MHz.
   localparam logic [CNT_W-1:0] BUS_FREE_CYCLES_DEF = 29'd250;       // 5 us
   localparam logic [CNT_W-1:0] TXN_GAP_CYCLES_DEF  = 29'd30000;     // 600 us
   localparam logic [CNT_W-1:0] TIMEOUT_CYCLES_DEF  = 29'd50000000;  // 1 s

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FREE_CHK = 2'd1,
      GRANT    = 2'd2,
      GAP      = 2'd3
   } arb_state_e;

   // Reduces a requester index that may have run one lap past the end
   // (sum < 2*modulus) back into 0..modulus-1.
   function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W:0] sum,
                                                 input int unsigned    modulus);
      logic [IDX_W:0] m;
      m = (IDX_W+1)'(modulus);
      return (sum >= m) ? IDX_W'(sum - m) : IDX_W'(sum);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr_i, wrapping modulo NUM_REQ, as both a one-hot vector and an index.
module rr_pick
   import i2c_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] onehot_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [IDX_W:0]       sum;

   // Rotate the request vector so ptr_i sits at bit 0, then take the lowest
   // set bit; scanning downwards lets the lowest offset win without a chain.
   // NOTE: every variable driven here gets a value before any branch, so no
   // path can leave one holding its old value and infer a latch.
   always_comb begin
      req_dbl = {req_i, req_i};
      req_rot = NUM_REQ'(req_dbl >> ptr_i);
      valid_o = 1'b0;
      sum     = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         if (req_rot[off]) begin
            valid_o = 1'b1;
            sum     = {1'b0, ptr_i} + (IDX_W+1)'(off);
         end
      end
      idx_o    = idx_wrap(sum, NUM_REQ);
      onehot_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one open-drain I2C bus between NUM_REQ transaction engines.
// A bus-free check precedes every grant, a fixed gap follows every release,
// grants rotate round-robin, and a watchdog revokes over-long grants.
module i2c_bus_arbiter
   import i2c_pkg::*;
#(
   parameter int               NUM_REQ         = 2,
   parameter logic [CNT_W-1:0] BUS_FREE_CYCLES = BUS_FREE_CYCLES_DEF,
   parameter logic [CNT_W-1:0] GAP_CYCLES      = TXN_GAP_CYCLES_DEF,
   parameter logic [CNT_W-1:0] TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   input  logic [NUM_REQ-1:0] req_scl_low,
   input  logic [NUM_REQ-1:0] req_sda_low,
   input  logic               scl_in,
   input  logic               sda_in,
   output logic               scl_low,
   output logic               sda_low,
   output logic               busy,
   output logic               timeout_err,
   output logic [2:0]         timeout_id
);

   arb_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   winner_q, winner_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               timeout_err_q, timeout_err_d;
   logic [IDX_W-1:0]   timeout_id_q, timeout_id_d;
   logic               scl_low_q, scl_low_d;
   logic               sda_low_q, sda_low_d;

   logic               scl_meta_q, scl_sync_q;
   logic               sda_meta_q, sda_sync_q;

   logic               bus_high;
   logic               owner_holds;
   logic               watchdog_fire;
   logic [IDX_W-1:0]   ptr_after_winner;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   // Two-flop synchronizers for the pad levels (slow_input_flop style).
   // NOTE: these flops carry no reset; they only shift pad samples through,
   // and reset neither clears nor needs to clear bus history.
   always_ff @(posedge clk) begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
   end

   assign bus_high         = scl_sync_q & sda_sync_q;
   assign owner_holds      = |(req & grant_q);
   assign watchdog_fire    = (TIMEOUT_CYCLES != '0) &&
                             (cnt_q == TIMEOUT_CYCLES - CNT_W'(1));
   assign ptr_after_winner = idx_wrap({1'b0, winner_q} + (IDX_W+1)'(1), NUM_REQ);

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_i    (req),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   // Next-state, counter, grant and watchdog decisions.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rr_ptr_d      = rr_ptr_q;
      winner_d      = winner_q;
      grant_d       = grant_q;
      timeout_err_d = timeout_err_q;
      timeout_id_d  = timeout_id_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (|req) state_d = FREE_CHK;
         end

         FREE_CHK: begin
            if (!pick_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!bus_high) begin
               cnt_d = '0;
            end else if (cnt_q == BUS_FREE_CYCLES - CNT_W'(1)) begin
               winner_d = pick_idx;
               grant_d  = pick_onehot;
               state_d  = GRANT;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         GRANT: begin
            // A release seen together with watchdog expiry is a plain release.
            if (!owner_holds || watchdog_fire) begin
               grant_d  = '0;
               rr_ptr_d = ptr_after_winner;
               state_d  = GAP;
               cnt_d    = '0;
               if (owner_holds) begin
                  timeout_err_d = 1'b1;
                  timeout_id_d  = winner_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt_q == GAP_CYCLES - CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = (|req) ? FREE_CHK : IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Pad drive follows the currently granted requester only.
   always_comb begin
      scl_low_d = |(req_scl_low & grant_q);
      sda_low_d = |(req_sda_low & grant_q);
   end

   // State and output registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rr_ptr_q      <= '0;
         winner_q      <= '0;
         grant_q       <= '0;
         timeout_err_q <= 1'b0;
         timeout_id_q  <= '0;
         scl_low_q     <= 1'b0;
         sda_low_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         winner_q      <= winner_d;
         grant_q       <= grant_d;
         timeout_err_q <= timeout_err_d;
         timeout_id_q  <= timeout_id_d;
         scl_low_q     <= scl_low_d;
         sda_low_q     <= sda_low_d;
      end
   end

   assign grant       = grant_q;
   assign scl_low     = scl_low_q;
   assign sda_low     = sda_low_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_err_q;
   assign timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus randomized requester
// engines, with every cycle compared against a behavioural model that
// tracks ownership, bus-high run length, gap time and hold time.
module tb_i2c_bus_arbiter;

   localparam int N   = 3;
   localparam int BF  = 6;
   localparam int GAP = 10;
   localparam int TO  = 40;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant;
   logic [N-1:0] req_scl_low = '0;
   logic [N-1:0] req_sda_low = '0;
   logic         scl_in = 1'b1;
   logic         sda_in = 1'b1;
   logic         scl_low, sda_low, busy, timeout_err;
   logic [2:0]   timeout_id;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   int m_owner = -1;   // granted requester, -1 when none
   int m_cool  = 0;    // gap cycles still to wait
   bit m_chk   = 0;    // waiting for the bus to be free
   int m_run   = 0;    // consecutive synchronized bus-high samples
   int m_held  = 0;    // cycles the current owner has held the bus
   int m_ptr   = 0;
   bit m_err   = 0;
   int m_id    = 0;
   bit m_scl   = 0;
   bit m_sda   = 0;
   bit h1 = 1, h2 = 1; // pad history, models the synchronizer delay

   // Random requester engines.
   bit auto_mode = 0;
   int off_left[N];
   int hold_left[N];

   i2c_bus_arbiter #(
      .NUM_REQ         (N),
      .BUS_FREE_CYCLES (29'(BF)),
      .GAP_CYCLES      (29'(GAP)),
      .TIMEOUT_CYCLES  (29'(TO))
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .req_scl_low (req_scl_low),
      .req_sda_low (req_sda_low),
      .scl_in      (scl_in),
      .sda_in      (sda_in),
      .scl_low     (scl_low),
      .sda_low     (sda_low),
      .busy        (busy),
      .timeout_err (timeout_err),
      .timeout_id  (timeout_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int idx_of(input logic [N-1:0] g);
      for (int k = 0; k < N; k++) if (g[k]) return k;
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_edge();
      bit bus;
      bus = h2;
      h2  = h1;
      h1  = scl_in & sda_in;
      if (reset) begin
         m_owner = -1; m_cool = 0; m_chk = 0; m_run = 0; m_held = 0;
         m_ptr = 0; m_err = 0; m_id = 0; m_scl = 0; m_sda = 0;
         return;
      end
      m_scl = 0;
      m_sda = 0;
      if (m_owner >= 0) begin
         m_scl = req_scl_low[m_owner];
         m_sda = req_sda_low[m_owner];
         m_held++;
         if (!req[m_owner] || m_held == TO) begin
            if (req[m_owner]) begin
               m_err = 1;
               m_id  = m_owner;
            end
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cool  = GAP;
         end
      end else if (m_cool > 0) begin
         m_cool--;
         if (m_cool == 0 && req != '0) begin
            m_chk = 1;
            m_run = 0;
         end
      end else if (m_chk) begin
         if (req == '0) m_chk = 0;
         else if (!bus) m_run = 0;
         else begin
            m_run++;
            if (m_run == BF) begin
               m_owner = m_pick(req, m_ptr);
               m_held  = 0;
               m_chk   = 0;
            end
         end
      end else if (req != '0) begin
         m_chk = 1;
         m_run = 0;
      end
   endtask

   function automatic int pick_hold();
      case ($urandom_range(0, 5))
         0:       return TO - 1;
         1:       return TO;
         2:       return TO + 1;
         3:       return 100;
         default: return $urandom_range(1, 30);
      endcase
   endfunction

   task automatic drive_engines();
      for (int i = 0; i < N; i++) begin
         if (!req[i]) begin
            if (off_left[i] > 0) off_left[i]--;
            else begin
               req[i]       = 1'b1;
               hold_left[i] = pick_hold();
            end
         end else if (grant[i]) begin
            hold_left[i]--;
            if (hold_left[i] <= 0) begin
               req[i]      = 1'b0;
               off_left[i] = $urandom_range(0, 15);
            end
         end else if ($urandom_range(0, 299) == 0) begin
            req[i]      = 1'b0;
            off_left[i] = $urandom_range(0, 15);
         end
      end
      req_scl_low = N'($urandom);
      req_sda_low = N'($urandom);
      scl_in      = ($urandom_range(0, 99) >= 4);
      sda_in      = ($urandom_range(0, 99) >= 4);
      reset       = ($urandom_range(0, 1499) == 0);
   endtask

   // One clock: update model at the edge, compare just after, then drive.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("grant",   32'(grant),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("scl_low", 32'(scl_low),     32'(m_scl));
      check("sda_low", 32'(sda_low),     32'(m_sda));
      check("busy",    32'(busy),        32'(m_owner >= 0 || m_cool > 0 || m_chk));
      check("t_err",   32'(timeout_err), 32'(m_err));
      check("t_id",    32'(timeout_id),  32'(m_id));
      if (auto_mode) drive_engines();
   endtask

   task automatic wait_grant(output int n, input int limit);
      n = 0;
      do begin
         step();
         n++;
      end while (grant == '0 && n < limit);
      if (grant == '0) check("grant_wait", 32'(grant != '0), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (busy && n < GAP + BF + 20);
      if (busy) check("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; req_scl_low = '0; req_sda_low = '0;
      scl_in = 1'b1; sda_in = 1'b1;
      repeat (3) step();
      reset = 1'b0;
   endtask

   initial begin
      int n, w, held;

      // Reset state.
      do_reset();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_err",   32'(timeout_err), 32'd0);
      check("rst_pads",  32'({scl_low, sda_low}), 32'd0);

      // Single request: latency and pad muxing.
      req = 3'b001; req_sda_low = 3'b010;
      wait_grant(n, 100);
      check("a_lat", 32'(n), 32'(1 + BF));
      check("a_sda_ign", 32'(sda_low), 32'd0);
      req_sda_low = 3'b011;
      step();
      check("a_sda_drv", 32'(sda_low), 32'd1);
      check("a_scl", 32'(scl_low), 32'd0);
      req = '0; req_sda_low = '0;
      wait_idle();

      // All requesting: round-robin order and gap length.
      do_reset();
      req = 3'b111;
      for (int g = 0; g < 4; g++) begin
         wait_grant(n, 200);
         w = idx_of(grant);
         check("rr_order", 32'(w), 32'(g % N));
         if (g > 0) check("rr_gap", 32'(n), 32'(GAP + BF));
         repeat (20) step();
         if (w >= 0) req[w] = 1'b0;
         step();
         req = 3'b111;
      end
      req = '0;
      wait_idle();

      // SCL glitch during the bus-free check restarts the count.
      do_reset();
      req = 3'b001;
      step();
      check("c_busy", 32'(busy), 32'd1);
      repeat (2) step();
      scl_in = 1'b0;
      repeat (3) step();
      scl_in = 1'b1;
      wait_grant(n, 100);
      check("c_glitch", 32'(n), 32'(BF + 2));
      req = '0;
      wait_idle();

      // Watchdog: requester 1 never releases.
      do_reset();
      req = 3'b010; req_scl_low = 3'b010; req_sda_low = 3'b010;
      wait_grant(n, 100);
      held = 1;
      for (int k = 0; k < TO + 10; k++) begin
         step();
         if (grant[1]) held++;
         else break;
      end
      check("d_len",   32'(held), 32'(TO));
      check("d_err",   32'(timeout_err), 32'd1);
      check("d_id",    32'(timeout_id), 32'd1);
      check("d_grant", 32'(grant), 32'd0);
      step();
      check("d_pads",  32'({scl_low, sda_low}), 32'd0);
      wait_grant(n, 100);
      check("d_regrant", 32'(n), 32'(GAP + BF - 1));
      req = '0; req_scl_low = '0; req_sda_low = '0;
      wait_idle();
      check("d_sticky", 32'(timeout_err), 32'd1);

      // Reset mid-grant drops grant and pads, and clears the pointer.
      do_reset();
      req = 3'b001;
      wait_grant(n, 100);
      req = '0;
      wait_idle();
      req = 3'b010;
      wait_grant(n, 100);
      req_sda_low = 3'b010;
      step();
      check("e_sda", 32'(sda_low), 32'd1);
      reset = 1'b1;
      step();
      check("e_grant", 32'(grant), 32'd0);
      check("e_sda_rst", 32'(sda_low), 32'd0);
      reset = 1'b0; req = 3'b011; req_sda_low = '0;
      wait_grant(n, 100);
      check("e_ptr", 32'(grant), 32'b001);
      check("e_lat", 32'(n), 32'(1 + BF));
      req = '0;
      wait_idle();

      // Release in the same cycle as watchdog expiry.
      do_reset();
      req = 3'b001;
      wait_grant(n, 100);
      for (int k = 1; k < TO; k++) step();
      check("f_held", 32'(grant), 32'b001);
      req = '0;
      step();
      check("f_err",   32'(timeout_err), 32'd0);
      check("f_busy",  32'(busy), 32'd1);
      check("f_grant", 32'(grant), 32'd0);
      wait_idle();

      // Randomized engines, pad drive, bus glitches and rare resets.
      do_reset();
      for (int i = 0; i < N; i++) begin
         off_left[i]  = $urandom_range(0, 10);
         hold_left[i] = 0;
      end
      auto_mode = 1;
      repeat (4000) step();
      auto_mode = 0;
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single board-level I2C bus (SCL/SDA to the ADV7513 and camera sensors) between NUM_REQ independent transaction engines, such as the ADV7513 init sequencer, the register reader and the camera config engines.
- Grants the bus to one requester at a time, round-robin, and muxes that requester's open-drain pull-low controls onto the pad drivers.
- Enforces a bus-free check before every grant and a fixed inter-transaction gap after every release.
- A watchdog revokes a grant held too long and reports it.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8).
- BUS_FREE_CYCLES, 29'd250, consecutive clk cycles with SCL=SDA=1 required before a grant (5us @50MHz).
- GAP_CYCLES, 29'd30000, idle cycles enforced after each release (600us @50MHz).
- TIMEOUT_CYCLES, 29'd50000000, maximum grant duration (1s @50MHz); 0 disables the watchdog.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester bus request, level; held high for the whole transaction.
- grant  out  NUM_REQ  one-hot grant; at most one bit set.
- req_scl_low  in  NUM_REQ  per-requester "pull SCL low" (1 = drive 0).
- req_sda_low  in  NUM_REQ  per-requester "pull SDA low".
- scl_in  in  1  sampled SCL pad level.
- sda_in  in  1  sampled SDA pad level.
- scl_low  out  1  to pad: 1 = drive SCL 0, else tri-state.
- sda_low  out  1  to pad: 1 = drive SDA 0, else tri-state.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set when the watchdog fires, cleared only by reset.
- timeout_id  out  3  index of the requester whose grant was revoked (valid when timeout_err=1).

Behaviour:
- Reset values: grant=0, scl_low=0, sda_low=0, busy=0, timeout_err=0, timeout_id=0, state=IDLE, counter=0, rr_ptr=0.
- Input sampling: scl_in and sda_in pass through a 2-flop synchronizer. The bus-free check uses the synchronized values.
- Pad outputs: scl_low = |(req_scl_low & grant), and likewise for SDA. Both are registered, giving 1 cycle latency from a requester input to the pad.
  - Non-granted requesters' drive inputs are ignored.
  - Outputs are 0 whenever grant=0.
- State IDLE:
  - counter=0.
  - If |req, go to FREE_CHK.
- State FREE_CHK:
  - Counter increments while synced SCL & SDA = 1, and clears to 0 on any low sample.
  - When counter reaches BUS_FREE_CYCLES-1 with the bus still high: latch the winner, set its grant bit, go to GRANT, clear counter.
  - Winner = first set req bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - If all req drop before the grant, return to IDLE.
- State GRANT:
  - grant is held and counter counts cycles of grant.
  - Requester deasserts req to release. On the cycle req[winner]=0 is seen: grant=0, rr_ptr=winner+1 (mod NUM_REQ), go to GAP, clear counter.
  - Watchdog: if TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1, force release the same way, set timeout_err=1 and timeout_id=winner.
  - A timed-out requester that keeps req high competes normally after the gap.
- State GAP:
  - grant=0, counter counts up.
  - At GAP_CYCLES-1, go to IDLE. If |req at that point, go directly to FREE_CHK instead.
- Simultaneous events:
  - Requests arriving during GRANT or GAP wait their turn.
  - A release and a watchdog expiry in the same cycle count as a normal release; timeout_err is not set.
  - New req bits never preempt an active grant.
- Fairness: strict round robin. With all requesters asserting continuously, grants rotate 0,1,…,NUM_REQ-1,0.
- Reset mid-grant: grant and pad outputs drop on the next clk edge. The requester engines see grant=0 and must abort; the bus is released within 1 cycle.
- grant is a registered output. The requester may begin driving the cycle after it sees grant high.
- Counter widths: 29 bits. All comparisons are against parameter-1, so a parameter value of 1 means a 1-cycle wait.

Decomposition:
- Package i2c_pkg holds:
  - the state encoding constants (IDLE=0, FREE_CHK=1, GRANT=2, GAP=3);
  - the default timing constants shared with the I2C engines (50 MHz-derived BUS_FREE, TXN gap, 1s timeout).
- One natural sub-module: rr_pick. It is combinational; it takes req, rr_ptr and NUM_REQ and returns a one-hot winner plus its index. It is reused by future arbiters.
- The 2-flop synchronizer uses the existing slow_input_flop-style cell.

Test Plan:
- Reset, then req=2'b01 with the bus high: grant=2'b01 exactly BUS_FREE_CYCLES cycles after the synchronizer delay. req_sda_low[0]=1 appears on sda_low 1 cycle later, and req_sda_low[1]=1 has no effect.
- req=2'b11 held continuously, with requester 0 releasing after 100 cycles: grant sequence is 01 → 00 for GAP_CYCLES → 10 → 00 → 01 (round robin verified over 4 grants).
- scl_in pulled low for 3 cycles midway through FREE_CHK: counter restarts and the grant is delayed by a full BUS_FREE_CYCLES from the last low sample.
- TIMEOUT_CYCLES=1000, requester 1 holds req forever: grant[1] drops at cycle 1000 of grant, timeout_err=1, timeout_id=1, scl_low=sda_low=0 the next cycle.
- reset asserted while grant=2'b10 with sda_low=1: the next edge gives grant=0 and sda_low=0, and after reset deasserts the arbiter re-enters IDLE with rr_ptr=0.
- Release and watchdog expiry in the same cycle: the arbiter enters GAP with timeout_err remaining 0.
